// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register as an elastic stage: valid/ready on both sides,
// a main entry that drives execute plus one skid entry, flush-to-bubble and a stall counter.
module id_ex_stage_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int WB_W   = 2,
   parameter int M_W    = 3,
   parameter int EX_W   = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WB_W-1:0]   ctlwb_in,
   input  logic [M_W-1:0]    ctlm_in,
   input  logic [EX_W-1:0]   ctlex_in,
   input  logic [DATA_W-1:0] npc_in,
   input  logic [DATA_W-1:0] rdata1_in,
   input  logic [DATA_W-1:0] rdata2_in,
   input  logic [DATA_W-1:0] signext_in,
   input  logic [REG_W-1:0]  instr_2016_in,
   input  logic [REG_W-1:0]  instr_1511_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WB_W-1:0]   wb_ctlout,
   output logic [M_W-1:0]    m_ctlout,
   output logic              regdst,
   output logic [EX_W-3:0]   aluop,
   output logic              alusrc,
   output logic [DATA_W-1:0] npcout,
   output logic [DATA_W-1:0] rdata1out,
   output logic [DATA_W-1:0] rdata2out,
   output logic [DATA_W-1:0] s_extendout,
   output logic [REG_W-1:0]  instrout_2016,
   output logic [REG_W-1:0]  instrout_1511,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int BEAT_W = WB_W + M_W + EX_W + 4*DATA_W + 2*REG_W;

   logic              main_valid;
   logic              skid_valid;
   logic [BEAT_W-1:0] in_beat;
   logic [BEAT_W-1:0] main_beat;
   logic [BEAT_W-1:0] skid_beat;
   logic [WB_W-1:0]   main_wb;
   logic [M_W-1:0]    main_m;
   logic [EX_W-1:0]   main_ex;
   logic              accept;
   logic              consume;

   assign in_beat = {ctlwb_in, ctlm_in, ctlex_in, npc_in, rdata1_in, rdata2_in,
                     signext_in, instr_2016_in, instr_1511_in};

   assign {main_wb, main_m, main_ex, npcout, rdata1out, rdata2out,
           s_extendout, instrout_2016, instrout_1511} = main_beat;

   // in_ready comes straight from the skid flag, so it never depends on out_ready.
   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;
   assign accept    = in_valid & in_ready;
   assign consume   = main_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_beat  <= '0;
         skid_beat  <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!main_valid || consume) begin
         if (skid_valid) begin
            main_beat  <= skid_beat;
            main_valid <= 1'b1;
            skid_valid <= accept;
            if (accept)
               skid_beat <= in_beat;
         end else begin
            main_valid <= accept;
            if (accept)
               main_beat <= in_beat;
         end
      end else if (accept) begin
         skid_beat  <= in_beat;
         skid_valid <= 1'b1;
      end
   end

   // Counts every stalled edge, flush included; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + 1'b1;
   end

   // Bubbles must carry all-zero controls so execute and later stages do nothing.
   assign wb_ctlout = main_valid ? main_wb : '0;
   assign m_ctlout  = main_valid ? main_m : '0;
   assign regdst    = main_valid & main_ex[EX_W-1];
   assign aluop     = main_valid ? main_ex[EX_W-2:1] : '0;
   assign alusrc    = main_valid & main_ex[0];

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed beats are queued on accept and a
// negedge monitor pops and compares every consumed beat.
module tb_id_ex_stage_reg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int WB_W   = 2;
   localparam int M_W    = 3;
   localparam int EX_W   = 4;
   localparam int CNT_W  = 3;

   typedef struct {
      logic [31:0] npc;
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [3:0]  ex;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [WB_W-1:0]   ctlwb_in;
   logic [M_W-1:0]    ctlm_in;
   logic [EX_W-1:0]   ctlex_in;
   logic [DATA_W-1:0] npc_in;
   logic [DATA_W-1:0] rdata1_in;
   logic [DATA_W-1:0] rdata2_in;
   logic [DATA_W-1:0] signext_in;
   logic [REG_W-1:0]  instr_2016_in;
   logic [REG_W-1:0]  instr_1511_in;
   logic              out_valid;
   logic              out_ready;
   logic [WB_W-1:0]   wb_ctlout;
   logic [M_W-1:0]    m_ctlout;
   logic              regdst;
   logic [EX_W-3:0]   aluop;
   logic              alusrc;
   logic [DATA_W-1:0] npcout;
   logic [DATA_W-1:0] rdata1out;
   logic [DATA_W-1:0] rdata2out;
   logic [DATA_W-1:0] s_extendout;
   logic [REG_W-1:0]  instrout_2016;
   logic [REG_W-1:0]  instrout_1511;
   logic [CNT_W-1:0]  stall_cnt;

   exp_t exp_q[$];
   exp_t mon_e;
   int   passed;
   int   total;
   logic acc;
   int   exp_cnt;
   int   tries;

   id_ex_stage_reg #(
      .DATA_W(DATA_W), .REG_W(REG_W), .WB_W(WB_W),
      .M_W(M_W), .EX_W(EX_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in),
      .npc_in(npc_in), .rdata1_in(rdata1_in), .rdata2_in(rdata2_in),
      .signext_in(signext_in), .instr_2016_in(instr_2016_in),
      .instr_1511_in(instr_1511_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .regdst(regdst),
      .aluop(aluop), .alusrc(alusrc),
      .npcout(npcout), .rdata1out(rdata1out), .rdata2out(rdata2out),
      .s_extendout(s_extendout), .instrout_2016(instrout_2016),
      .instrout_1511(instrout_1511), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath fields are derived from npc so each beat is distinguishable.
   function automatic logic [31:0] r1Of(input logic [31:0] npc);
      return npc ^ 32'hDEAD_0000;
   endfunction
   function automatic logic [31:0] r2Of(input logic [31:0] npc);
      return npc + 32'h0000_0100;
   endfunction
   function automatic logic [31:0] seOf(input logic [31:0] npc);
      return ~npc;
   endfunction
   function automatic logic [4:0] rtOf(input logic [31:0] npc);
      return npc[6:2];
   endfunction
   function automatic logic [4:0] rdOf(input logic [31:0] npc);
      return ~npc[6:2];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      else
         passed++;
   endtask

   // Drives one cycle of input starting just after a rising edge; returns whether it was accepted.
   task automatic applyStimulus(input logic v, input logic [31:0] npc, input logic [3:0] ex,
                                input logic [1:0] wb, input logic [2:0] m, input logic fl,
                                output logic accepted);
      exp_t e;
      in_valid      = v;
      flush         = fl;
      npc_in        = npc;
      rdata1_in     = r1Of(npc);
      rdata2_in     = r2Of(npc);
      signext_in    = seOf(npc);
      instr_2016_in = rtOf(npc);
      instr_1511_in = rdOf(npc);
      ctlex_in      = ex;
      ctlwb_in      = wb;
      ctlm_in       = m;
      accepted      = v && in_ready;
      if (accepted && !fl) begin
         e.npc = npc; e.wb = wb; e.m = m; e.ex = ex;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      if (fl)
         exp_q.delete();
   endtask

   task automatic drainAll();
      logic a;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() == 0 && !out_valid)
            break;
         applyStimulus(1'b0, 32'h0, 4'h0, 2'h0, 3'h0, 1'b0, a);
      end
      checkOutput("drain_queue_empty", 32'(exp_q.size()), 32'd0);
      checkOutput("drain_out_valid", 32'(out_valid), 32'd0);
   endtask

   task automatic doReset();
      rst = 1'b1;
      #1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: every consume handshake must match the oldest expected beat.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("mon_npc", npcout, mon_e.npc);
            checkOutput("mon_rdata1", rdata1out, r1Of(mon_e.npc));
            checkOutput("mon_rdata2", rdata2out, r2Of(mon_e.npc));
            checkOutput("mon_sext", s_extendout, seOf(mon_e.npc));
            checkOutput("mon_rt", 32'(instrout_2016), 32'(rtOf(mon_e.npc)));
            checkOutput("mon_rd", 32'(instrout_1511), 32'(rdOf(mon_e.npc)));
            checkOutput("mon_ctl", 32'({wb_ctlout, m_ctlout, regdst, aluop, alusrc}),
                        32'({mon_e.wb, mon_e.m, mon_e.ex}));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      passed = 0; total = 0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      ctlwb_in = '0; ctlm_in = '0; ctlex_in = '0;
      npc_in = '0; rdata1_in = '0; rdata2_in = '0; signext_in = '0;
      instr_2016_in = '0; instr_1511_in = '0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      checkOutput("rst_ctl", 32'({wb_ctlout, m_ctlout, regdst, aluop, alusrc}), 32'd0);
      rst = 1'b0;

      // Streaming at full throughput
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'(4 * (i + 1)), 4'(3 * i + 1), 2'(i), 3'(i + 1), 1'b0, acc);
         checkOutput("stream_accept", 32'(acc), 32'd1);
         checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
         checkOutput("stream_out_valid", 32'(out_valid), 32'd1);
         checkOutput("stream_npc", npcout, 32'(4 * (i + 1)));
      end
      applyStimulus(1'b0, 32'h0, 4'h0, 2'h0, 3'h0, 1'b0, acc);
      checkOutput("stream_idle_valid", 32'(out_valid), 32'd0);
      checkOutput("stream_stall_cnt", 32'(stall_cnt), 32'd0);

      // Backpressure fills main then skid
      out_ready = 1'b0;
      applyStimulus(1'b1, 32'h4, 4'b0010, 2'b01, 3'b001, 1'b0, acc);
      checkOutput("bp_in_ready_1", 32'(in_ready), 32'd1);
      checkOutput("bp_npc_1", npcout, 32'h4);
      applyStimulus(1'b1, 32'h8, 4'b0100, 2'b10, 3'b010, 1'b0, acc);
      checkOutput("bp_in_ready_2", 32'(in_ready), 32'd0);
      checkOutput("bp_npc_2", npcout, 32'h4);
      applyStimulus(1'b1, 32'hC, 4'b1000, 2'b11, 3'b100, 1'b0, acc);
      checkOutput("bp_c_held_off", 32'(acc), 32'd0);
      checkOutput("bp_npc_3", npcout, 32'h4);
      checkOutput("bp_stall_cnt", 32'(stall_cnt), 32'd2);
      out_ready = 1'b1;
      tries = 0;
      do begin
         applyStimulus(1'b1, 32'hC, 4'b1000, 2'b11, 3'b100, 1'b0, acc);
         tries++;
      end while (!acc && tries < 5);
      checkOutput("bp_c_accepted", 32'(acc), 32'd1);
      checkOutput("bp_c_tries", 32'(tries), 32'd2);
      drainAll();

      // Flush with both entries occupied and a beat presented
      out_ready = 1'b0;
      applyStimulus(1'b1, 32'h20, 4'b1101, 2'b11, 3'b111, 1'b0, acc);
      applyStimulus(1'b1, 32'h24, 4'b1101, 2'b11, 3'b111, 1'b0, acc);
      checkOutput("fl_skid_full", 32'(in_ready), 32'd0);
      applyStimulus(1'b1, 32'h28, 4'b1101, 2'b11, 3'b111, 1'b1, acc);
      checkOutput("fl_out_valid", 32'(out_valid), 32'd0);
      checkOutput("fl_wb", 32'(wb_ctlout), 32'd0);
      checkOutput("fl_m", 32'(m_ctlout), 32'd0);
      checkOutput("fl_ex", 32'({regdst, aluop, alusrc}), 32'd0);
      checkOutput("fl_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      applyStimulus(1'b0, 32'h0, 4'h0, 2'h0, 3'h0, 1'b0, acc);
      checkOutput("fl_no_ghost", 32'(out_valid), 32'd0);

      // Control decode, then stall counter saturation
      doReset();
      checkOutput("cd_stall_cleared", 32'(stall_cnt), 32'd0);
      out_ready = 1'b0;
      applyStimulus(1'b1, 32'h30, 4'b1011, 2'b10, 3'b101, 1'b0, acc);
      checkOutput("cd_regdst", 32'(regdst), 32'd1);
      checkOutput("cd_aluop", 32'(aluop), 32'b01);
      checkOutput("cd_alusrc", 32'(alusrc), 32'd1);
      checkOutput("cd_wb", 32'(wb_ctlout), 32'b10);
      checkOutput("cd_m", 32'(m_ctlout), 32'b101);
      exp_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 32'h0, 4'h0, 2'h0, 3'h0, 1'b0, acc);
         exp_cnt = (exp_cnt == 7) ? 7 : exp_cnt + 1;
         checkOutput("sat_stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
      end
      applyStimulus(1'b0, 32'h0, 4'h0, 2'h0, 3'h0, 1'b1, acc);
      checkOutput("sat_after_flush", 32'(stall_cnt), 32'd7);
      checkOutput("sat_flush_valid", 32'(out_valid), 32'd0);
      doReset();
      checkOutput("sat_after_rst", 32'(stall_cnt), 32'd0);

      // Asynchronous reset between edges with both entries full
      out_ready = 1'b0;
      applyStimulus(1'b1, 32'h40, 4'b1111, 2'b11, 3'b111, 1'b0, acc);
      applyStimulus(1'b1, 32'h44, 4'b1111, 2'b11, 3'b111, 1'b0, acc);
      checkOutput("ar_pre_valid", 32'(out_valid), 32'd1);
      checkOutput("ar_pre_in_ready", 32'(in_ready), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("ar_out_valid", 32'(out_valid), 32'd0);
      checkOutput("ar_ctl", 32'({wb_ctlout, m_ctlout, regdst, aluop, alusrc}), 32'd0);
      checkOutput("ar_in_ready", 32'(in_ready), 32'd1);
      checkOutput("ar_stall_cnt", 32'(stall_cnt), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      drainAll();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Parametrised, clocked ID/EX pipeline register for the lab MIPS datapath.
- Replaces the untimed combinational latch with an elastic stage: valid/ready handshake both sides, 2-entry skid buffer, flush-to-bubble and a stall-cycle counter.
- Sits between decode (control unit, register file, sign-extend) and execute (ALU, regdst mux).

Parameters:
- DATA_W, 32, width of npc, rdata1, rdata2, signext fields
- REG_W, 5, width of rt/rd register-address fields
- WB_W, 2, width of WB control group
- M_W, 3, width of MEM control group
- EX_W, 4, width of EX control group (legal values 3 or more)
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all held and incoming beats this cycle
- in_valid  in  1  decode presents a beat
- in_ready  out  1  stage can accept a beat
- ctlwb_in  in  WB_W  WB controls
- ctlm_in  in  M_W  MEM controls
- ctlex_in  in  EX_W  EX controls {regdst, aluop[EX_W-3:0], alusrc}
- npc_in, rdata1_in, rdata2_in, signext_in  in  DATA_W each  datapath fields
- instr_2016_in, instr_1511_in  in  REG_W each  rt, rd
- out_valid  out  1  execute-side beat present
- out_ready  in  1  execute consumes the beat
- wb_ctlout  out  WB_W
- m_ctlout  out  M_W
- regdst  out  1  = ctlex[EX_W-1]
- aluop  out  EX_W-2  = ctlex[EX_W-2:1]
- alusrc  out  1  = ctlex[0]
- npcout, rdata1out, rdata2out, s_extendout  out  DATA_W each
- instrout_2016, instrout_1511  out  REG_W each
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each with a valid bit.
- Handshake:
  - accept = in_valid and in_ready
  - consume = out_valid and out_ready
- in_ready is registered and equals NOT skid_valid. A beat is never dropped except by flush.
- out_valid = main_valid.
- Latency: a beat accepted at edge N appears on the outputs after edge N if main was empty or consumed at that edge. Throughput is 1 beat/cycle while out_ready=1.
- Next-state rules, applied at each rising edge when flush=0:
  - Main empty or consumed, skid valid: skid moves to main, skid_valid=0; an accept loads skid.
  - Main empty or consumed, skid empty: an accept loads main directly.
  - Main held (valid, not consumed), accept: the beat loads skid and in_ready deasserts.
- Simultaneous consume and accept with skid full is impossible, because in_ready=0.
- Flush has priority over everything:
  - Next edge: main_valid=0, skid_valid=0, in_ready=1.
  - Any beat accepted in the flush cycle is discarded.
  - The consume handshake in the flush cycle still counts as completed.
- Bubble guarantee: wb_ctlout, m_ctlout, regdst, aluop and alusrc are forced to 0 whenever out_valid=0, by combinational gating of the main control registers.
- Data outputs (npcout through instrout_1511) hold their last main-entry value when invalid. They are don't-care to execute.
- Datapath fields pass unmodified, no width conversion.
- stall_cnt:
  - Increments by 1 on each edge where out_valid=1 and out_ready=0.
  - Saturates at all-ones.
  - Not cleared by flush; cleared only by rst.
- Reset (async assert, sync-safe deassert):
  - All registers 0, so out_valid=0, all outputs 0, stall_cnt=0.
  - in_ready=1 while rst is high and after release.
- Reset mid-transfer discards both entries immediately.

Test Plan:
- Reset then stream: rst pulse, then 4 beats npc_in=0x4,0x8,0xC,0x10 with out_ready=1 -> each appears one cycle later, out_valid continuous, in_ready stays 1, stall_cnt=0.
- Backpressure/skid: out_ready=0 while beats 0x4, 0x8 accepted -> outputs hold 0x4, in_ready=0 after second accept, third beat 0xC is held off. Raise out_ready -> outputs 0x4, 0x8, 0xC in order, none lost or duplicated.
- Flush bubble: main and skid both full, ctlex_in=4'b1101, flush=1 for one cycle with in_valid=1 -> next cycle out_valid=0, regdst/aluop/alusrc/wb/m outputs=0, in_ready=1, flushed input absent.
- Control decode: ctlex_in=4'b1011, ctlwb_in=2'b10, ctlm_in=3'b101 -> regdst=1, aluop=2'b01, alusrc=1, wb_ctlout=2'b10, m_ctlout=3'b101.
- Stall counter saturation with CNT_W=3: out_valid=1, out_ready=0 for 10 cycles -> stall_cnt counts 1..7 then stays at 7. Flush leaves it at 7; rst returns it to 0.
- Async reset mid-operation: assert rst between clock edges with both entries full -> out_valid and all control outputs go 0 immediately without a clock edge, in_ready=1.
